// File: rtl/field_edit_pkg.sv
// field_edit_pkg: shared state type, default sizes and group indices for the field edit controller
package field_edit_pkg;
  typedef enum logic {IDLE, EDIT} edit_state_t;
  localparam int DEF_N_GRP = 3;
  localparam int DEF_N_FLD = 3;
  localparam int GRP_HORA  = 0;
  localparam int GRP_FECHA = 1;
  localparam int GRP_CRONO = 2;
endpackage

// File: rtl/field_pos_counter.sv
// field_pos_counter: up/down mod-N_FLD field position with sync clear; up+dn together holds
module field_pos_counter #(
  parameter int N_FLD = 3,
  localparam int POS_W = $clog2(N_FLD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             up,
  input  logic             dn,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] pos_nxt
);
  localparam logic [POS_W-1:0] TOP = POS_W'(N_FLD - 1);
  always_comb
    pos_nxt = clr ? '0 :
              (up && !dn) ? ((pos == TOP) ? '0 : pos + POS_W'(1)) :
              (dn && !up) ? ((pos == '0) ? TOP : pos - POS_W'(1)) : pos;
  always_ff @(posedge clk or posedge reset)
    if (reset) pos <= '0;
    else pos <= pos_nxt;
endmodule

// File: rtl/field_edit_ctrl.sv
// field_edit_ctrl: edit-field write-enable controller for the register bank
// FIELD_EDIT_TIMEOUT_EN adds an idle auto-exit after TIMEOUT_CYC cycles in EDIT
module field_edit_ctrl
  import field_edit_pkg::*;
#(
  parameter int N_GRP = DEF_N_GRP,
  parameter int N_FLD = DEF_N_FLD,
  parameter int TIMEOUT_CYC = 1000,
  localparam int POS_W = $clog2(N_FLD),
  localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_GRP-1:0]       grp_sel,
  input  logic                   btn_next,
  input  logic                   btn_prev,
  input  logic                   btn_exit,
  output logic [N_GRP*N_FLD-1:0] en_out,
  output logic [POS_W-1:0]       pos_out,
  output logic [GRP_W-1:0]       grp_out,
  output logic                   editing
);
  localparam int EN_W = N_GRP * N_FLD;
  edit_state_t state, state_nxt;
  logic [GRP_W-1:0] lo, grp_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic [EN_W-1:0] en_nxt;
  logic any, edit, chg, leave, tmo_hit, clr, mv_up, mv_dn;
  always_comb begin
    lo = '0;
    for (int i = N_GRP - 1; i >= 0; i--)
      if (grp_sel[i]) lo = GRP_W'(i);
  end
  assign any  = |grp_sel;
  assign edit = (state == EDIT);
  assign chg  = edit && any && (lo != grp_out);
`ifdef FIELD_EDIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo;
  logic act;
  // any user activity restarts the idle count, so a press on the final cycle wins
  assign act     = btn_next || btn_prev || btn_exit || chg || !any;
  assign tmo_hit = edit && (tmo == TW'(TIMEOUT_CYC)) && !act;
  always_ff @(posedge clk or posedge reset)
    if (reset) tmo <= '0;
    else tmo <= (!edit || act || tmo_hit) ? '0 : tmo + TW'(1);
`else
  assign tmo_hit = 1'b0;
`endif
  assign leave     = edit && (btn_exit || !any || tmo_hit);
  assign state_nxt = edit ? (leave ? IDLE : EDIT) : (any ? EDIT : IDLE);
  assign clr       = (!edit && any) || (chg && !btn_exit);
  assign grp_nxt   = clr ? lo : grp_out;
  assign mv_up     = edit && !leave && !chg && btn_next;
  assign mv_dn     = edit && !leave && !chg && btn_prev;
  assign en_nxt    = (state_nxt == EDIT) ? (EN_W'(1) << (int'(grp_nxt) * N_FLD + int'(pos_nxt))) : '0;
  field_pos_counter #(.N_FLD(N_FLD)) u_pos (
    .clk(clk), .reset(reset), .clr(clr), .up(mv_up), .dn(mv_dn), .pos(pos_out), .pos_nxt(pos_nxt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      grp_out <= '0;
      en_out  <= '0;
      editing <= 1'b0;
    end else begin
      state   <= state_nxt;
      grp_out <= grp_nxt;
      en_out  <= en_nxt;
      editing <= (state_nxt == EDIT);
    end
endmodule
